// File: rtl/conf_chain_writer_pkg.sv
// Shared definitions for the configuration-chain writer and the frame-address sequencer:
// state encoding and the phase-timer width helper.
package conf_chain_writer_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_WAITW = 3'd1,
    S_SETUP = 3'd2,
    S_PHA   = 3'd3,
    S_GAPA  = 3'd4,
    S_PHB   = 3'd5,
    S_GAPB  = 3'd6,
    S_DONE  = 3'd7
  } cw_state_e;

  // Wide enough to hold the longer of the pulse and gap lengths.
  function automatic int unsigned phase_timer_w(input int unsigned pulse_cyc,
                                                input int unsigned gap_cyc);
    return $clog2(((pulse_cyc > gap_cyc) ? pulse_cyc : gap_cyc) + 1);
  endfunction

endpackage

// File: rtl/conf_chain_writer_phase_timer.sv
// Down-counting phase timer: load a cycle count, expired_o is high on the final cycle.
module conf_phase_timer #(
  parameter int unsigned TMR_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i - TMR_W'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TMR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/conf_chain_writer.sv
// Serial config-chain writer with non-overlapping two-phase latch enables.
// Optional readback of the chain tail when CONF_READBACK_EN is defined.
module conf_chain_writer
  import conf_chain_writer_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned PULSE_CYC = 1,
  parameter int unsigned GAP_CYC   = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              conf_data,
  output logic              conf_pha,
  output logic              conf_phb,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bits_sent
`ifdef CONF_READBACK_EN
  ,
  input  logic              conf_ret,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
`endif
);

  localparam int unsigned TMR_W = phase_timer_w(PULSE_CYC, GAP_CYC);
  localparam int unsigned IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYC);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

  cw_state_e         state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              last_q, last_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pha_q, phb_q, ready_q, busy_q, done_q;
  logic              tmr_load, tmr_exp;
  logic [TMR_W-1:0]  tmr_val;

  conf_phase_timer #(.TMR_W(TMR_W)) u_timer (
    .clk_i      (CLK),
    .rst_ni     (RESETn),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_exp)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    last_d   = last_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    tmr_load = 1'b0;
    tmr_val  = PULSE_LD;
    unique case (state_q)
      S_IDLE, S_WAITW: begin
        if (s_valid) begin
          shreg_d = s_data;
          last_d  = s_last;
          idx_d   = IDX_LAST;
          cnt_d   = (state_q == S_IDLE) ? '0 : cnt_q;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        tmr_load = 1'b1;
        tmr_val  = PULSE_LD;
        state_d  = S_PHA;
      end
      S_PHA: begin
        if (tmr_exp) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
          state_d  = S_GAPA;
        end
      end
      S_GAPA: begin
        if (tmr_exp) begin
          tmr_load = 1'b1;
          tmr_val  = PULSE_LD;
          state_d  = S_PHB;
        end
      end
      S_PHB: begin
        if (tmr_exp) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
          state_d  = S_GAPB;
        end
      end
      S_GAPB: begin
        if (tmr_exp) begin
          cnt_d   = cnt_q + CNT_W'(1);
          shreg_d = shreg_q << 1;
          if (idx_q != '0) begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = S_SETUP;
          end else begin
            state_d = last_q ? S_DONE : S_WAITW;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Enables are decoded from the next state so they leave a flop cleanly
  // and the async reset clears them without waiting for a clock.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      pha_q   <= 1'b0;
      phb_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pha_q   <= (state_d == S_PHA);
      phb_q   <= (state_d == S_PHB);
      ready_q <= (state_d == S_IDLE) || (state_d == S_WAITW);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign conf_data = shreg_q[WORD_W-1];
  assign conf_pha  = pha_q;
  assign conf_phb  = phb_q;
  assign s_ready   = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign bits_sent = cnt_q;

`ifdef CONF_READBACK_EN
  logic [WORD_W-1:0] rb_sh_q, rb_data_q, rb_word;
  logic              rb_valid_q, bit_end, word_end;

  assign bit_end  = (state_q == S_GAPB) && tmr_exp;
  assign word_end = bit_end && (idx_q == '0);
  assign rb_word  = {rb_sh_q[WORD_W-2:0], conf_ret};

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rb_sh_q    <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_valid_q <= word_end;
      if (bit_end) rb_sh_q <= rb_word;
      if (word_end) rb_data_q <= rb_word;
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`endif

endmodule

// File: tb/tb_conf_chain_writer.sv
// Self-checking bench for conf_chain_writer: table of single-word frames plus
// hand-written back-to-back, WAITW-stall, mid-pulse reset and slow-timing sequences.
module tb_conf_chain_writer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RESETn;
  logic [31:0] s_data;
  logic        s_valid, s_last, s_ready;
  logic        conf_data, conf_pha, conf_phb, busy, done;
  logic [15:0] bits_sent;

  logic [7:0]  s1_data;
  logic        s1_valid, s1_last, s1_ready;
  logic        c1_data, c1_pha, c1_phb, busy1, done1;
  logic [15:0] bits1;

`ifdef CONF_READBACK_EN
  logic        conf_ret, c1_ret, rb_valid, rb1_valid;
  logic [31:0] rb_data;
  logic [7:0]  rb1_data;
`endif

  conf_chain_writer #(.WORD_W(32), .PULSE_CYC(1), .GAP_CYC(1), .CNT_W(16)) dut0 (
    .CLK(CLK), .RESETn(RESETn), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .conf_data(conf_data), .conf_pha(conf_pha), .conf_phb(conf_phb),
    .busy(busy), .done(done), .bits_sent(bits_sent)
`ifdef CONF_READBACK_EN
    , .conf_ret(conf_ret), .rb_data(rb_data), .rb_valid(rb_valid)
`endif
  );

  conf_chain_writer #(.WORD_W(8), .PULSE_CYC(2), .GAP_CYC(3), .CNT_W(16)) dut1 (
    .CLK(CLK), .RESETn(RESETn), .s_data(s1_data), .s_valid(s1_valid), .s_last(s1_last),
    .s_ready(s1_ready), .conf_data(c1_data), .conf_pha(c1_pha), .conf_phb(c1_phb),
    .busy(busy1), .done(done1), .bits_sent(bits1)
`ifdef CONF_READBACK_EN
    , .conf_ret(c1_ret), .rb_data(rb1_data), .rb_valid(rb1_valid)
`endif
  );

  typedef struct {
    logic [31:0] word;
    int          exp_bits;
    int          exp_done_cyc;
  } vec_t;
  vec_t vecs[5];

  int errors = 0;
  int checks = 0;

  int cyc, pha_cnt, phb_cnt, done_cnt, done_cyc, done_busy, ready_busy_cnt, ovl_cnt;
  int done1_cnt, done1_cyc;
  logic pha_prev, phb_prev, pha1_prev, phb1_prev;
  bit sb_q[$];
  bit sb1_q[$];
  int p1_rise[$], p1_fall[$], b1_rise[$];
  logic [31:0] chain;
  logic [31:0] rb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One clock: advance to the falling edge and run both monitors/scoreboards.
  task automatic step();
    bit want;
    @(negedge CLK);
    cyc++;
    if (conf_pha && !pha_prev) begin
      pha_cnt++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL conf_data: phase-A pulse with no expected bit queued");
      end else begin
        want = sb_q.pop_front();
        if (conf_data !== want) begin
          errors++;
          $display("FAIL conf_data: got %0b, want %0b at bit %0d", conf_data, want, pha_cnt - 1);
        end
      end
    end
    if (conf_phb && !phb_prev) begin
      phb_cnt++;
`ifdef CONF_READBACK_EN
      conf_ret = chain[31];
`endif
      chain = {chain[30:0], conf_data};
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_busy = int'(busy);
    end
    if (s_ready && busy) ready_busy_cnt++;
    if ((conf_pha && conf_phb) || (conf_pha && phb_prev) || (conf_phb && pha_prev)) ovl_cnt++;
    if ((c1_pha && c1_phb) || (c1_pha && phb1_prev) || (c1_phb && pha1_prev)) ovl_cnt++;
    if (c1_pha && !pha1_prev) begin
      p1_rise.push_back(cyc);
      if (sb1_q.size() != 0) begin
        want = sb1_q.pop_front();
        check("c1_data", 32'(c1_data), 32'(want));
      end
    end
    if (!c1_pha && pha1_prev) p1_fall.push_back(cyc);
    if (c1_phb && !phb1_prev) b1_rise.push_back(cyc);
    if (done1) begin
      done1_cnt++;
      done1_cyc = cyc;
    end
`ifdef CONF_READBACK_EN
    if (rb_valid) rb_q.push_back(rb_data);
`endif
    pha_prev  = conf_pha;
    phb_prev  = conf_phb;
    pha1_prev = c1_pha;
    phb1_prev = c1_phb;
  endtask

  task automatic clear_mon();
    pha_cnt = 0; phb_cnt = 0; done_cnt = 0; done_cyc = 0; done_busy = 0;
    ready_busy_cnt = 0; done1_cnt = 0; done1_cyc = 0;
    sb_q.delete(); sb1_q.delete();
    p1_rise.delete(); p1_fall.delete(); b1_rise.delete();
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    s_data  = w;
    s_last  = last;
    s_valid = 1'b1;
    for (int i = 31; i >= 0; i--) sb_q.push_back(w[i]);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
      if (done_cnt != 0) s_valid = 1'b0;
    end
    check("done_seen", 32'(done_cnt != 0), 32'd1);
  endtask

  initial begin
    int t0, n, bad;
    logic held;

    vecs[0] = '{32'hA500_0000, 32, 161};
    vecs[1] = '{32'hFFFF_FFFF, 32, 161};
    vecs[2] = '{32'h0000_0000, 32, 161};
    vecs[3] = '{32'h8000_0001, 32, 161};
    vecs[4] = '{32'hDEAD_BEEF, 32, 161};

    RESETn = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    s1_data = '0; s1_valid = 1'b0; s1_last = 1'b0;
    chain = '0; cyc = 0; ovl_cnt = 0;
    pha_prev = 1'b0; phb_prev = 1'b0; pha1_prev = 1'b0; phb1_prev = 1'b0;
`ifdef CONF_READBACK_EN
    conf_ret = 1'b0; c1_ret = 1'b0;
`endif
    #2 RESETn = 1'b0;
    #1;
    check("rst_pha", 32'(conf_pha), 32'd0);
    check("rst_phb", 32'(conf_phb), 32'd0);
    check("rst_data", 32'(conf_data), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bits", 32'(bits_sent), 32'd0);
    step(); step();
    RESETn = 1'b1;
    step();

    // Single-word frames from the table.
    for (int v = 0; v < 5; v++) begin
      clear_mon();
      t0 = cyc;
      send_word(vecs[v].word, 1'b1);
      step();
      s_valid = 1'b0;
      wait_done(400);
      step(); step();
      check("done_cycle", 32'(done_cyc - t0), 32'(vecs[v].exp_done_cyc));
      check("pha_pulses", 32'(pha_cnt), 32'(vecs[v].exp_bits));
      check("phb_pulses", 32'(phb_cnt), 32'(vecs[v].exp_bits));
      check("bits_sent", 32'(bits_sent), 32'(vecs[v].exp_bits));
      check("done_count", 32'(done_cnt), 32'd1);
      check("busy_in_done", 32'(done_busy), 32'd1);
      check("busy_after", 32'(busy), 32'd0);
      check("ready_after", 32'(s_ready), 32'd1);
      check("sb_drained", 32'(sb_q.size()), 32'd0);
    end

    // Back-to-back words with s_valid held high.
    clear_mon();
    t0 = cyc;
    send_word(32'h1357_9BDF, 1'b0);
    step();
    send_word(32'hC3C3_5A5A, 1'b1);
    wait_done(800);
    step(); step();
    check("b2b_done_cycle", 32'(done_cyc - t0), 32'd322);
    check("b2b_bits", 32'(bits_sent), 32'd64);
    check("b2b_pulses", 32'(pha_cnt), 32'd64);
    check("b2b_done_count", 32'(done_cnt), 32'd1);
    check("b2b_ready_gap", 32'(ready_busy_cnt), 32'd1);
    check("b2b_sb_drained", 32'(sb_q.size()), 32'd0);

    // Stall in WAITW for 20 cycles.
    clear_mon();
    send_word(32'h1234_5678, 1'b0);
    step();
    s_valid = 1'b0;
    n = 0;
    while (!(s_ready && busy) && n < 300) begin step(); n++; end
    check("waitw_reached", 32'(s_ready && busy), 32'd1);
    held = conf_data;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (conf_pha || conf_phb || conf_data !== held || !busy || !s_ready) bad++;
    end
    check("waitw_hold", 32'(bad), 32'd0);
    check("waitw_bits", 32'(bits_sent), 32'd32);
    send_word(32'h0F0F_0F0F, 1'b1);
    step();
    s_valid = 1'b0;
    wait_done(400);
    step();
    check("waitw_total_bits", 32'(bits_sent), 32'd64);
    check("waitw_done_count", 32'(done_cnt), 32'd1);

    // Async reset during phase A of bit 5.
    clear_mon();
    send_word(32'hFFFF_FFFF, 1'b1);
    step();
    s_valid = 1'b0;
    n = 0;
    while (!(bits_sent == 16'd5 && conf_pha) && n < 100) begin step(); n++; end
    check("mid_pha_reached", 32'(bits_sent == 16'd5 && conf_pha), 32'd1);
    #2 RESETn = 1'b0;
    #1;
    check("rst_mid_pha", 32'(conf_pha), 32'd0);
    check("rst_mid_bits", 32'(bits_sent), 32'd0);
    check("rst_mid_ready", 32'(s_ready), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    step(); step();
    RESETn = 1'b1;
    step();
    clear_mon();
    t0 = cyc;
    send_word(32'hA500_0000, 1'b1);
    step();
    s_valid = 1'b0;
    wait_done(400);
    step();
    check("post_rst_done_cycle", 32'(done_cyc - t0), 32'd161);
    check("post_rst_bits", 32'(bits_sent), 32'd32);
    check("post_rst_pulses", 32'(pha_cnt), 32'd32);

    // Slow timing instance: PULSE_CYC=2, GAP_CYC=3, 8-bit words.
    clear_mon();
    t0 = cyc;
    s1_data = 8'h5A; s1_last = 1'b1; s1_valid = 1'b1;
    for (int i = 7; i >= 0; i--) sb1_q.push_back(s1_data[i]);
    step();
    s1_valid = 1'b0;
    n = 0;
    while (done1_cnt == 0 && n < 200) begin step(); n++; end
    step();
    check("slow_done_seen", 32'(done1_cnt), 32'd1);
    check("slow_done_cycle", 32'(done1_cyc - t0), 32'd89);
    check("slow_pulses", 32'(p1_rise.size()), 32'd8);
    check("slow_bits", 32'(bits1), 32'd8);
    check("slow_sb_drained", 32'(sb1_q.size()), 32'd0);
    if (p1_rise.size() >= 2 && p1_fall.size() >= 1 && b1_rise.size() >= 1) begin
      check("slow_pha_high", 32'(p1_fall[0] - p1_rise[0]), 32'd2);
      check("slow_gap", 32'(b1_rise[0] - p1_fall[0]), 32'd3);
      check("slow_period", 32'(p1_rise[1] - p1_rise[0]), 32'd11);
    end else begin
      checks++;
      errors++;
      $display("FAIL slow_edges: too few phase edges recorded (%0d)", p1_rise.size());
    end

`ifdef CONF_READBACK_EN
    clear_mon();
    chain = '0;
    conf_ret = 1'b0;
    rb_q.delete();
    send_word(32'hDEAD_BEEF, 1'b0);
    step();
    send_word(32'h0000_0000, 1'b1);
    wait_done(800);
    step(); step();
    check("rb_count", 32'(rb_q.size()), 32'd2);
    if (rb_q.size() == 2) begin
      check("rb_first", rb_q[0], 32'h0000_0000);
      check("rb_second", rb_q[1], 32'hDEAD_BEEF);
    end
`endif

    check("no_overlap", 32'(ovl_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
